conv3x3_stream: RTL and testbench
=================================

// Module: conv3x3_stream
// PURPOSE
//  Streaming 3x3 2-D convolution engine: raster pixels in, one filtered pixel per interior window out.
//  Runtime-loadable signed kernel, normalising shift and output mode. Frame-aware row/col counters.
//  Border windows are suppressed, so the output frame is (IMG_W-2)x(IMG_H-2) with no row wrap-around.
//  Sits between the pixel source and the CNN pooling/activation stages of the image pipeline.
// PARAMETERS
//  WORD_SIZE   8    pixel width, unsigned
//  IMG_W       540  pixels per row (>=3)
//  IMG_H       540  rows per frame (>=3)
//  COEF_W      5    signed kernel coefficient width
//  SHIFT_W     3    width of normalising right-shift amount
// PORTS
//  clk         in   1          rising-edge clock
//  rst         in   1          asynchronous, active-high reset
//  in_valid    in   1          in_pixel is valid this cycle; no backpressure
//  in_pixel    in   WORD_SIZE  raster-order input pixel
//  coef_we     in   1          write one shadow coefficient
//  coef_addr   in   4          0..8 = row*3+col; 9..15 ignored
//  coef_data   in   COEF_W     signed coefficient
//  cfg_shift   in   SHIFT_W    arithmetic right shift applied to sum; sampled at frame start
//  cfg_abs     in   1          0: clamp; 1: absolute value then saturate; sampled at frame start
//  out_valid   out  1          out_pixel valid
//  out_pixel   out  WORD_SIZE  filtered pixel
//  out_sof     out  1          with out_valid: first output pixel of a frame
//  out_eol     out  1          with out_valid: last output pixel of an output row
// BEHAVIOUR
//  Reset (async): all outputs 0; col/row counters 0; pipeline valids 0; active+shadow kernel =
//   Laplacian {-1,-1,-1,-1,8,-1,-1,-1,-1}; active shift 0, abs 0. Line-buffer contents unspecified.
//  Counters advance only on in_valid; col wraps IMG_W-1->0 and increments row; row wraps IMG_H-1->0.
//  in_valid low: nothing shifts, pipeline bubbles; output sequence identical to the gapless case.
//  Window: 2 line buffers of IMG_W + 3x3 register window; window valid iff accepted pixel has col>=2 & row>=2.
//  Output = window centred one row and one column back; kernel tap [0][0] multiplies oldest (top-left) pixel.
//  Pipeline: stage1 9 products, stage2 adder tree, stage3 shift/saturate register.
//   out_valid exactly 3 cycles after the clk edge accepting the qualifying pixel.
//  Arithmetic: product WORD_SIZE+COEF_W+1 signed; sum WORD_SIZE+COEF_W+5 signed, never overflows.
//   s = sum >>> active_shift; clamp mode: s<0->0, s>2^WORD_SIZE-1 -> max, else s.
//   abs mode: |s| saturated to 2^WORD_SIZE-1.
//  Coefficients: coef_we writes the shadow bank any time. Shadow->active copy, plus cfg_shift/cfg_abs
//   capture, happens when the pixel at (row0,col0) is accepted. A frame never uses a mixed kernel.
//  Same-cycle coef_we and frame-start copy: the copy takes the pre-write shadow value; the write lands next frame.
//  out_sof on the output for accepted pixel (2,2). out_eol on outputs for accepted col IMG_W-1, row>=2.
//  Reset mid-frame aborts in-flight outputs (none emitted); the next accepted pixel is (0,0).
// STRUCTURE
//  conv_pkg:
//   - coef_t (signed COEF_W)
//   - kernel_t (coef_t [3][3])
//   - LAPLACIAN default-kernel constant
//   - out_mode_e {CLAMP, ABS}
//  Sub-module conv_line_buffer: 2-row shift/RAM line store + 3x3 window + col/row counters + window_valid.
//  Top: coefficient banks, 3-stage MAC pipeline, valid/sof/eol sideband delay chain.
// TESTING (bench IMG_W=8, IMG_H=6)
//  - Flat image, all 100, Laplacian, no gaps -> 24 outputs, all 0; first out_valid 3 cycles after
//    accepting pixel (2,2); exactly 4 out_eol; 1 out_sof.
//  - Single 255 at (3,3), others 0, clamp mode -> centre output 255 (2040 saturated), 8 neighbours 0.
//    Same with cfg_abs=1 -> neighbours 255.
//  - Shadow write mid-frame: box kernel (all 1), cfg_shift=3.
//    -> current frame still Laplacian; next all-80 frame gives 90 (720>>>3) everywhere.
//  - Random in_valid duty 30-100% -> output pixel/sof/eol sequence identical to gapless run.
//  - Kernel all -1, pixel 255 image.
//    -> clamp 0; abs saturate 255; sum width proven with no overflow at max coef -16.
//  - rst asserted mid-row 3 -> outputs 0 asynchronously, no stale out_valid.
//    Next frame processes from (0,0) with Laplacian.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared types for the 3x3 convolution engine: coefficient/kernel types,
// the power-up Laplacian kernel and the output post-processing mode.
package conv_pkg;

  localparam int COEF_W_DEF = 5;

  typedef logic signed [COEF_W_DEF-1:0] coef_t;
  typedef coef_t kernel_t [3][3];

  // Edge-detect kernel loaded into both banks on reset
  localparam kernel_t LAPLACIAN = '{
    '{coef_t'(-1), coef_t'(-1), coef_t'(-1)},
    '{coef_t'(-1), coef_t'(8),  coef_t'(-1)},
    '{coef_t'(-1), coef_t'(-1), coef_t'(-1)}
  };

  typedef enum logic {
    CLAMP = 1'b0,
    ABS   = 1'b1
  } out_mode_e;

endpackage

// File: rtl/conv3x3_stream_if.sv
// Pixel stream bundle: raster pixels into the engine, filtered pixels out.
// Latency: n/a (wires only).
// Backpressure: none; the source pushes with in_valid, the sink must accept every out_valid.
interface conv3x3_stream_if #(
  parameter int WORD_SIZE = 8
);
  logic                 in_valid;
  logic [WORD_SIZE-1:0] in_pixel;
  logic                 out_valid;
  logic [WORD_SIZE-1:0] out_pixel;
  logic                 out_sof;
  logic                 out_eol;

  // Pixel source / result sink side
  modport master (
    output in_valid, in_pixel,
    input  out_valid, out_pixel, out_sof, out_eol
  );

  // Convolution engine side
  modport slave (
    input  in_valid, in_pixel,
    output out_valid, out_pixel, out_sof, out_eol
  );
endinterface

// File: rtl/conv_line_buffer.sv
// Two-row line store plus 3x3 sliding window with frame row/col counters.
// Latency: window and its valid/sof/eol flags are registered on the accepting edge.
// Backpressure: none; everything advances only on in_valid.
module conv_line_buffer #(
  parameter int WORD_SIZE = 8,
  parameter int IMG_W     = 540,
  parameter int IMG_H     = 540
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [WORD_SIZE-1:0] in_pixel,
  output logic                 frame_start,
  output logic [WORD_SIZE-1:0] win [3][3],
  output logic                 win_valid,
  output logic                 win_sof,
  output logic                 win_eol
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_TWO  = CW'(2);
  localparam logic [RW-1:0] ROW_TWO  = RW'(2);

  logic [CW-1:0]        col;
  logic [RW-1:0]        row;
  logic [WORD_SIZE-1:0] lb_top [IMG_W];  // row r-2
  logic [WORD_SIZE-1:0] lb_mid [IMG_W];  // row r-1
  logic [WORD_SIZE-1:0] tap_top;
  logic [WORD_SIZE-1:0] tap_mid;
  logic                 interior;

  assign tap_top     = lb_top[col];
  assign tap_mid     = lb_mid[col];
  assign interior    = (col >= COL_TWO) && (row >= ROW_TWO);
  assign frame_start = in_valid && (col == '0) && (row == '0);

  // Raster position of the next pixel to be accepted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col <= '0;
      row <= '0;
    end else if (in_valid) begin
      if (col == COL_LAST) begin
        col <= '0;
        row <= (row == ROW_LAST) ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  // Line store: each column slot ages one row per accepted pixel
  always_ff @(posedge clk) begin
    if (in_valid) begin
      lb_top[col] <= tap_mid;
      lb_mid[col] <= in_pixel;
    end
  end

  // Window slides left; the new right column is {row r-2, r-1, r}
  always_ff @(posedge clk) begin
    if (in_valid) begin
      for (int r = 0; r < 3; r++) begin
        win[r][0] <= win[r][1];
        win[r][1] <= win[r][2];
      end
      win[0][2] <= tap_top;
      win[1][2] <= tap_mid;
      win[2][2] <= in_pixel;
    end
  end

  // Window qualifiers; a gap cycle produces a bubble rather than a repeat
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_valid <= 1'b0;
      win_sof   <= 1'b0;
      win_eol   <= 1'b0;
    end else begin
      win_valid <= in_valid && interior;
      win_sof   <= in_valid && (col == COL_TWO) && (row == ROW_TWO);
      win_eol   <= in_valid && interior && (col == COL_LAST);
    end
  end
endmodule

// File: rtl/conv3x3_stream.sv
// Streaming 3x3 convolution: interior windows only, runtime kernel, shift and clamp/abs.
// Latency: out_valid 3 cycles after the edge accepting the window's last pixel.
// Backpressure: none; gaps on in_valid become output bubbles.
module conv3x3_stream
  import conv_pkg::*;
#(
  parameter int WORD_SIZE = 8,
  parameter int IMG_W     = 540,
  parameter int IMG_H     = 540,
  parameter int COEF_W    = 5,
  parameter int SHIFT_W   = 3
) (
  input  logic                clk,
  input  logic                rst,
  conv3x3_stream_if.slave     bus,
  input  logic                coef_we,
  input  logic [3:0]          coef_addr,
  input  logic [COEF_W-1:0]   coef_data,
  input  logic [SHIFT_W-1:0]  cfg_shift,
  input  logic                cfg_abs
);
  localparam int PW = WORD_SIZE + COEF_W + 1;
  localparam int SW = WORD_SIZE + COEF_W + 5;
  localparam logic signed [SW-1:0] PIX_MAX = SW'((1 << WORD_SIZE) - 1);

  logic                        frame_start;
  logic [WORD_SIZE-1:0]        win [3][3];
  logic                        win_valid, win_sof, win_eol;

  logic signed [COEF_W-1:0]    shadow_k [3][3];
  logic signed [COEF_W-1:0]    active_k [3][3];
  logic [SHIFT_W-1:0]          active_shift;
  out_mode_e                   active_mode;

  logic signed [PW-1:0]        prod [3][3];
  logic                        s1_vld, s1_sof, s1_eol;
  logic [SHIFT_W-1:0]          s1_shift;
  out_mode_e                   s1_mode;

  logic signed [SW-1:0]        tree_sum, s2_sum;
  logic                        s2_vld, s2_sof, s2_eol;
  logic [SHIFT_W-1:0]          s2_shift;
  out_mode_e                   s2_mode;

  logic signed [SW-1:0]        shifted, mag;
  logic [WORD_SIZE-1:0]        sat_pix;

  conv_line_buffer #(
    .WORD_SIZE (WORD_SIZE),
    .IMG_W     (IMG_W),
    .IMG_H     (IMG_H)
  ) u_lb (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (bus.in_valid),
    .in_pixel    (bus.in_pixel),
    .frame_start (frame_start),
    .win         (win),
    .win_valid   (win_valid),
    .win_sof     (win_sof),
    .win_eol     (win_eol)
  );

  // Shadow bank written any time; whole bank plus shift/mode snapshot at frame start.
  // A write coinciding with the snapshot lands in shadow after the copy reads it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          shadow_k[r][c] <= COEF_W'(LAPLACIAN[r][c]);
          active_k[r][c] <= COEF_W'(LAPLACIAN[r][c]);
        end
      end
      active_shift <= '0;
      active_mode  <= CLAMP;
    end else begin
      if (frame_start) begin
        for (int r = 0; r < 3; r++) begin
          for (int c = 0; c < 3; c++) begin
            active_k[r][c] <= shadow_k[r][c];
          end
        end
        active_shift <= cfg_shift;
        active_mode  <= out_mode_e'(cfg_abs);
      end
      if (coef_we) begin
        for (int r = 0; r < 3; r++) begin
          for (int c = 0; c < 3; c++) begin
            if (coef_addr == 4'(r * 3 + c)) shadow_k[r][c] <= coef_data;
          end
        end
      end
    end
  end

  // Stage 1: nine products; shift/mode travel with the data so the next frame's
  // snapshot cannot affect the tail of the current one
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) prod[r][c] <= '0;
      end
      s1_vld   <= 1'b0;
      s1_sof   <= 1'b0;
      s1_eol   <= 1'b0;
      s1_shift <= '0;
      s1_mode  <= CLAMP;
    end else begin
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          prod[r][c] <= PW'($signed({1'b0, win[r][c]})) * PW'(active_k[r][c]);
        end
      end
      s1_vld   <= win_valid;
      s1_sof   <= win_sof;
      s1_eol   <= win_eol;
      s1_shift <= active_shift;
      s1_mode  <= active_mode;
    end
  end

  // Adder tree over the nine sign-extended products
  always_comb begin
    tree_sum = '0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) tree_sum = tree_sum + SW'(prod[r][c]);
    end
  end

  // Stage 2: register the sum
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_sum   <= '0;
      s2_vld   <= 1'b0;
      s2_sof   <= 1'b0;
      s2_eol   <= 1'b0;
      s2_shift <= '0;
      s2_mode  <= CLAMP;
    end else begin
      s2_sum   <= tree_sum;
      s2_vld   <= s1_vld;
      s2_sof   <= s1_sof;
      s2_eol   <= s1_eol;
      s2_shift <= s1_shift;
      s2_mode  <= s1_mode;
    end
  end

  // Normalise, optional magnitude, then saturate into the pixel range
  always_comb begin
    shifted = s2_sum >>> s2_shift;
    mag     = (s2_mode == ABS && shifted[SW-1]) ? -shifted : shifted;
    sat_pix = mag[WORD_SIZE-1:0];
    if (mag[SW-1])          sat_pix = '0;
    else if (mag > PIX_MAX) sat_pix = '1;
  end

  // Stage 3: output register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.out_valid <= 1'b0;
      bus.out_pixel <= '0;
      bus.out_sof   <= 1'b0;
      bus.out_eol   <= 1'b0;
    end else begin
      bus.out_valid <= s2_vld;
      bus.out_sof   <= s2_vld && s2_sof;
      bus.out_eol   <= s2_vld && s2_eol;
      if (s2_vld) bus.out_pixel <= sat_pix;
    end
  end
endmodule

// File: tb/tb_conv3x3_stream.sv
// Directed bench for conv3x3_stream on an 8x6 frame.
module tb_conv3x3_stream;
  localparam int W    = 8;
  localparam int IW   = 8;
  localparam int IH   = 6;
  localparam int OW   = IW - 2;
  localparam int NOUT = (IW - 2) * (IH - 2);

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       coef_we = 1'b0;
  logic [3:0] coef_addr = '0;
  logic [4:0] coef_data = '0;
  logic [2:0] cfg_shift = '0;
  logic       cfg_abs = 1'b0;

  always #5 clk = ~clk;

  conv3x3_stream_if #(.WORD_SIZE(W)) bus ();

  conv3x3_stream #(
    .WORD_SIZE (W),
    .IMG_W     (IW),
    .IMG_H     (IH),
    .COEF_W    (5),
    .SHIFT_W   (3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .coef_we   (coef_we),
    .coef_addr (coef_addr),
    .coef_data (coef_data),
    .cfg_shift (cfg_shift),
    .cfg_abs   (cfg_abs)
  );

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  int first_cyc = -1;
  int acc_cyc   = -1;
  int cur_pat   = 0;
  int q_pix[$];
  int q_sof[$];
  int q_eol[$];

  // Reference kernel/config the bench expects the DUT to apply to the frame
  int m_k[9];
  int m_shift = 0;
  int m_abs   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.out_valid === 1'b1) begin
      if (q_pix.size() == 0) first_cyc = cyc;
      q_pix.push_back(int'(bus.out_pixel));
      q_sof.push_back(int'(bus.out_sof));
      q_eol.push_back(int'(bus.out_eol));
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int pat_px(input int pat, input int r, input int c);
    case (pat)
      0:       return 100;
      1:       return (r == 3 && c == 3) ? 255 : 0;
      2:       return 80;
      3:       return 255;
      default: return (r * 37 + c * 11 + r * c * 5) & 255;
    endcase
  endfunction

  // Direct convolution of the window whose top-left is (orow, ocol)
  function automatic int ref_out(input int orow, input int ocol);
    int s;
    s = 0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        s += m_k[i * 3 + j] * pat_px(cur_pat, orow + i, ocol + j);
    s = s >>> m_shift;
    if (m_abs != 0 && s < 0) s = -s;
    if (s < 0) s = 0;
    if (s > 255) s = 255;
    return s;
  endfunction

  function automatic int qpx(input int i);
    if (i < q_pix.size()) return q_pix[i];
    return -1;
  endfunction

  function automatic void model_lap();
    for (int i = 0; i < 9; i++) m_k[i] = (i == 4) ? 8 : -1;
  endfunction

  function automatic void model_uniform(input int v);
    for (int i = 0; i < 9; i++) m_k[i] = v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_kernel(input int v);
    for (int a = 0; a < 9; a++) begin
      coef_we = 1'b1; coef_addr = 4'(a); coef_data = 5'(v);
      tick();
    end
    coef_we = 1'b0;
  endtask

  task automatic write_lap();
    for (int a = 0; a < 9; a++) begin
      coef_we = 1'b1; coef_addr = 4'(a); coef_data = (a == 4) ? 5'd8 : 5'h1f;
      tick();
    end
    coef_we = 1'b0;
  endtask

  task automatic drive_px(input int p, input int duty);
    if (duty < 100)
      while ($urandom_range(0, 99) >= duty) tick();
    bus.in_valid = 1'b1;
    bus.in_pixel = 8'(p);
    tick();
    bus.in_valid = 1'b0;
  endtask

  // hook 1: load box kernel + shift 3 mid-frame; hook 2: write centre=-16 with pixel (0,0)
  task automatic run_frame(input int pat, input int duty, input int hook);
    q_pix.delete(); q_sof.delete(); q_eol.delete();
    first_cyc = -1; acc_cyc = -1; cur_pat = pat;
    for (int i = 0; i < IW * IH; i++) begin
      if (hook == 1 && i == 20) begin
        write_kernel(1);
        cfg_shift = 3'd3;
      end
      if (hook == 2 && i == 0) begin
        coef_we = 1'b1; coef_addr = 4'd4; coef_data = 5'b10000;
      end
      drive_px(pat_px(pat, i / IW, i % IW), duty);
      coef_we = 1'b0;
      if (i == 2 * IW + 2) acc_cyc = cyc;
    end
    repeat (8) tick();
  endtask

  task automatic check_frame(input string tag);
    check($sformatf("%s_count", tag), q_pix.size(), NOUT);
    for (int i = 0; i < NOUT && i < q_pix.size(); i++) begin
      check($sformatf("%s_px%0d", tag, i), q_pix[i], ref_out(i / OW, i % OW));
      check($sformatf("%s_sof%0d", tag, i), q_sof[i], (i == 0) ? 1 : 0);
      check($sformatf("%s_eol%0d", tag, i), q_eol[i], (i % OW == OW - 1) ? 1 : 0);
    end
  endtask

  initial begin
    int nsof, neol;
    bus.in_valid = 1'b0;
    bus.in_pixel = '0;
    model_lap();
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", int'(bus.out_valid), 0);
    check("rst_out_pixel", int'(bus.out_pixel), 0);
    check("rst_out_sof", int'(bus.out_sof), 0);
    check("rst_out_eol", int'(bus.out_eol), 0);
    rst = 1'b0;
    tick();

    // Flat 100, Laplacian
    run_frame(0, 100, 0);
    check_frame("flat");
    check("flat_latency", first_cyc - acc_cyc, 3);
    nsof = 0; neol = 0;
    foreach (q_sof[i]) begin nsof += q_sof[i]; neol += q_eol[i]; end
    check("flat_sof_total", nsof, 1);
    check("flat_eol_total", neol, 4);

    // Impulse, clamp then abs
    run_frame(1, 100, 0);
    check_frame("imp_clamp");
    check("imp_clamp_centre", qpx(14), 255);
    check("imp_clamp_nbr", qpx(7), 0);
    cfg_abs = 1'b1; m_abs = 1;
    run_frame(1, 100, 0);
    check_frame("imp_abs");
    check("imp_abs_nbr", qpx(7), 255);
    check("imp_abs_far", qpx(0), 0);

    // Mid-frame shadow write must not touch the running frame
    cfg_abs = 1'b0; m_abs = 0;
    run_frame(2, 100, 1);
    check_frame("shadow_cur");
    model_uniform(1); m_shift = 3;
    run_frame(2, 100, 0);
    check_frame("box");
    check("box_val", qpx(0), 90);

    // All -1 kernel on a 255 image
    write_kernel(-1);
    cfg_shift = 3'd0; m_shift = 0; model_uniform(-1);
    run_frame(3, 100, 0);
    check_frame("neg_clamp");
    cfg_abs = 1'b1; m_abs = 1; cfg_shift = 3'd4; m_shift = 4;
    run_frame(3, 100, 2);
    check_frame("neg_abs_s4");
    check("neg_abs_s4_val", qpx(5), 144);
    m_k[4] = -16;
    run_frame(3, 100, 0);
    check_frame("late_write");
    check("late_write_val", qpx(5), 255);

    // Most negative coefficient everywhere: sum -36720 must stay negative
    write_kernel(-16);
    cfg_abs = 1'b0; m_abs = 0; cfg_shift = 3'd0; m_shift = 0; model_uniform(-16);
    run_frame(3, 100, 0);
    check_frame("min_coef");

    // Gapless vs gapped input on a textured image
    write_lap();
    cfg_abs = 1'b1; m_abs = 1; model_lap();
    run_frame(4, 100, 0);
    check_frame("tex_gapless");
    run_frame(4, 30, 0);
    check_frame("tex_duty30");
    check("tex_duty30_latency", first_cyc - acc_cyc, 3);
    run_frame(4, 60, 0);
    check_frame("tex_duty60");

    // Reset in the middle of row 3
    cur_pat = 4;
    for (int i = 0; i < 3 * IW + 6; i++) drive_px(pat_px(4, i / IW, i % IW), 100);
    check("pre_rst_valid", int'(bus.out_valid), 1);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_valid", int'(bus.out_valid), 0);
    check("async_rst_pixel", int'(bus.out_pixel), 0);
    check("async_rst_eol", int'(bus.out_eol), 0);
    tick();
    rst = 1'b0;
    q_pix.delete(); q_sof.delete(); q_eol.delete();
    repeat (6) tick();
    check("post_rst_no_stale", q_pix.size(), 0);
    cfg_abs = 1'b0; m_abs = 0; cfg_shift = 3'd0; m_shift = 0; model_lap();
    run_frame(1, 100, 0);
    check_frame("post_rst");
    check("post_rst_centre", qpx(14), 255);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
